// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared pipeline-control definitions. Holds the register
//               specifier width, the zero-register encoding and the bit
//               layout of the ID/EX field bundle, so the decoder and the
//               hazard controller agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // ID/EX field bundle layout: {rd, rt, rs, mult, load}
    localparam int c_IDEX_LOAD_BIT = 0;
    localparam int c_IDEX_MULT_BIT = 1;
    localparam int c_IDEX_RS_LSB   = 2;
    localparam int c_IDEX_RT_LSB   = c_IDEX_RS_LSB + REG_W;
    localparam int c_IDEX_RD_LSB   = c_IDEX_RT_LSB + REG_W;
    localparam int c_IDEX_W        = c_IDEX_RD_LSB + REG_W;

    // True when a produced register is nonzero and matches a consumed one;
    // register 0 is hard-wired and never creates a dependency.
    function automatic logic dep_match(input logic [REG_W-1:0] produced,
                                       input logic [REG_W-1:0] consumed);
        return (produced != REG_ZERO) && (produced == consumed);
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/mul_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mul_busy_ctr
// Description : Occupancy timer of the shared multi-cycle multiplier. Loads
//               MUL_LAT on issue, counts down to zero, and remembers the
//               destination register of the in-flight multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_busy_ctr #(
    parameter int MUL_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REG_W-1:0] start_rd,
    output logic             busy,
    output logic             wb,
    output logic [REG_W-1:0] rd
);

    logic [CNT_W-1:0] r_cnt;
    logic [REG_W-1:0] r_rd;

    // Load on issue, otherwise decrement while nonzero so the count saturates at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_rd  <= '0;
        end else if (start) begin
            r_cnt <= CNT_W'(MUL_LAT);
            r_rd  <= start_rd;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign busy = (r_cnt != '0);
    assign wb   = (r_cnt == CNT_W'(1));
    assign rd   = r_rd;

endmodule : mul_busy_ctr
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : ID-stage hazard sequencer. Drives hold/kill strobes of the
//               IF/ID and ID/EX registers for load-use stalls, taken-branch
//               and jump flushes and multiplier interlocks, and issues the
//               shared multi-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int REG_W   = pipe_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rt,
    input  logic             id_mult,
    input  logic             id_jflag,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_br_tkn,
    output logic             if_hold,
    output logic             if_kill,
    output logic             id_hold,
    output logic             id_kill,
    output logic             mul_start,
    output logic             mul_busy,
    output logic             mul_wb,
    output logic [REG_W-1:0] mul_rd
);

    import pipe_ctrl_pkg::*;

    logic w_lu;
    logic w_mb;
    logic w_stl;

    mul_busy_ctr #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W),
        .REG_W   (REG_W)
    ) u_mul_busy_ctr (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .start_rd (id_rd),
        .busy     (mul_busy),
        .wb       (mul_wb),
        .rd       (mul_rd)
    );

    // Hazard detection: load-use, multiplier interlock, and the combined stall
    always_comb begin
        w_lu  = ex_load & id_valid &
                (dep_match(ex_rt, id_rs) | (id_use_rt & dep_match(ex_rt, id_rt)));
        w_mb  = mul_busy & id_valid &
                (id_mult | dep_match(mul_rd, id_rs) | dep_match(mul_rd, id_rt));
        w_stl = (w_lu | w_mb) & ~ex_br_tkn;
    end

    // Priority network: reset, taken branch, stall, jump, idle
    always_comb begin
        if_hold   = 1'b0;
        if_kill   = 1'b0;
        id_hold   = 1'b0;
        id_kill   = 1'b0;
        mul_start = 1'b0;
        if (rst) begin
            if_kill = 1'b1;
            id_kill = 1'b1;
        end else begin
            mul_start = id_valid & id_mult & ~w_stl & ~ex_br_tkn;
            if (ex_br_tkn) begin
                if_kill = 1'b1;
                id_kill = 1'b1;
            end else if (w_stl) begin
                if_hold = 1'b1;
                id_kill = 1'b1;
            end else if (id_jflag & id_valid) begin
                if_kill = 1'b1;
            end
        end
    end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl with a
//               4-cycle multiplier latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 6;
    localparam int REG_W   = 5;

    // Expected output vector order: {if_hold, if_kill, id_hold, id_kill, mul_start, mul_busy, mul_wb}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_RST   = 7'b0101000;
    localparam logic [6:0] O_STALL = 7'b1001000;
    localparam logic [6:0] O_FLUSH = 7'b0101000;
    localparam logic [6:0] O_JUMP  = 7'b0100000;
    localparam logic [6:0] O_ISSUE = 7'b0000100;
    localparam logic [6:0] O_STLB  = 7'b1001010;
    localparam logic [6:0] O_STLWB = 7'b1001011;
    localparam logic [6:0] O_BUSY  = 7'b0000010;
    localparam logic [6:0] O_FLB   = 7'b0101010;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rt;
    logic             id_mult;
    logic             id_jflag;
    logic             ex_load;
    logic [REG_W-1:0] ex_rt;
    logic             ex_br_tkn;
    logic             if_hold;
    logic             if_kill;
    logic             id_hold;
    logic             id_kill;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_wb;
    logic [REG_W-1:0] mul_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W),
        .REG_W   (REG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_use_rt (id_use_rt),
        .id_mult   (id_mult),
        .id_jflag  (id_jflag),
        .ex_load   (ex_load),
        .ex_rt     (ex_rt),
        .ex_br_tkn (ex_br_tkn),
        .if_hold   (if_hold),
        .if_kill   (if_kill),
        .id_hold   (id_hold),
        .id_kill   (id_kill),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .mul_wb    (mul_wb),
        .mul_rd    (mul_rd)
    );

    task automatic chk_out(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {if_hold, if_kill, id_hold, id_kill, mul_start, mul_busy, mul_wb};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [REG_W-1:0] exp);
        checks++;
        assert (mul_rd === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, mul_rd, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        id_rs     = '0;
        id_rt     = '0;
        id_rd     = '0;
        id_use_rt = 1'b0;
        id_mult   = 1'b0;
        id_jflag  = 1'b0;
        ex_load   = 1'b0;
        ex_rt     = '0;
        ex_br_tkn = 1'b0;
    endtask

    task automatic id_instr(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                            input logic [REG_W-1:0] rd, input logic use_rt,
                            input logic mult);
        id_valid  = 1'b1;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_use_rt = use_rt;
        id_mult   = mult;
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 2 later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #3;
        chk_out("reset_outputs", O_RST);
        chk_rd("reset_mul_rd", '0);
        next_cycle();
        rst = 1'b0;
        #2;
        chk_out("idle_after_reset", O_IDLE);

        // Load-use on rs, lasting exactly one cycle
        next_cycle();
        id_instr(5'd5, 5'd3, 5'd8, 1'b1, 1'b0);
        ex_load = 1'b1; ex_rt = 5'd5;
        #2; chk_out("lu_rs_stall", O_STALL);
        next_cycle();
        ex_load = 1'b0; ex_rt = 5'd0;
        #2; chk_out("lu_rs_released", O_IDLE);
        next_cycle();
        ex_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd5;
        #2; chk_out("lu_reg0_nostall", O_IDLE);
        next_cycle();
        id_rs = 5'd0;
        #2; chk_out("lu_reg0_both0", O_IDLE);

        // Load-use on rt gated by id_use_rt
        next_cycle();
        id_instr(5'd4, 5'd7, 5'd8, 1'b0, 1'b0);
        ex_load = 1'b1; ex_rt = 5'd7;
        #2; chk_out("lu_rt_unused", O_IDLE);
        next_cycle();
        id_use_rt = 1'b1;
        #2; chk_out("lu_rt_used", O_STALL);

        // Taken branch overrides a stall and blocks a mult issue
        next_cycle();
        id_mult = 1'b1; ex_br_tkn = 1'b1;
        #2; chk_out("branch_over_stall", O_FLUSH);
        next_cycle();
        idle_inputs();
        #2; chk_out("branch_no_issue", O_IDLE);

        // Jump
        next_cycle();
        id_instr(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        id_jflag = 1'b1;
        #2; chk_out("jump", O_JUMP);
        next_cycle();
        id_valid = 1'b0;
        #2; chk_out("jump_bubble_ignored", O_IDLE);

        // Multiply timing: mult r9, then add r1,r9,r2 waits for write-back
        next_cycle();
        idle_inputs();
        id_instr(5'd3, 5'd4, 5'd9, 1'b1, 1'b1);
        #2; chk_out("mul_issue", O_ISSUE);
        next_cycle();
        id_instr(5'd9, 5'd2, 5'd1, 1'b1, 1'b0);
        #2; chk_out("mul_dep_c1", O_STLB);
        chk_rd("mul_rd_latched", 5'd9);
        next_cycle();
        #2; chk_out("mul_dep_c2", O_STLB);
        next_cycle();
        #2; chk_out("mul_dep_c3", O_STLB);
        next_cycle();
        #2; chk_out("mul_dep_c4_wb", O_STLWB);
        next_cycle();
        #2; chk_out("mul_dep_released", O_IDLE);

        // Combined stall, second mult interlock, branch keeps multiply, reset at cnt=2
        next_cycle();
        id_instr(5'd3, 5'd4, 5'd6, 1'b1, 1'b1);
        #2; chk_out("mul2_issue", O_ISSUE);
        next_cycle();
        id_instr(5'd6, 5'd2, 5'd1, 1'b1, 1'b0);
        ex_load = 1'b1; ex_rt = 5'd6;
        #2; chk_out("combined_stall", O_STLB);
        next_cycle();
        ex_load = 1'b0; ex_rt = 5'd0;
        id_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        #2; chk_out("second_mult_blocked", O_STLB);
        next_cycle();
        idle_inputs();
        ex_br_tkn = 1'b1;
        #2; chk_out("branch_keeps_mul", O_FLB);
        #1;
        rst = 1'b1;
        #1; chk_out("async_reset_mid_mul", O_RST);
        chk_rd("async_reset_mul_rd", '0);
        ex_br_tkn = 1'b0;
        next_cycle();
        chk_out("reset_held_no_wb", O_RST);
        rst = 1'b0;
        #2; chk_out("after_reset_c1", O_IDLE);
        next_cycle();
        #2; chk_out("after_reset_c2", O_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
